// File: rtl/freq_meter.sv
// Gated frequency counter: counts rising edges of an asynchronous input over a
// window of GATE_CYCLES clk cycles and reports the count with a one-cycle valid.
// Optional build macro FREQ_METER_GLITCH_FILTER_EN inserts a 3-sample majority
// filter between the synchronizer and the edge detector.
//
// Handshake: valid is a one-cycle pulse and needs no ready. count and overflow
// change only in the valid cycle or on reset, and are held until the next valid.
// start is sampled only in IDLE. continuous is a level that is sampled in IDLE
// and in DONE.
module freq_meter #(
    parameter int GATE_CYCLES = 100_000_000,
    parameter int CNT_W       = 27
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sig_in,
    input  logic             start,
    input  logic             continuous,
    output logic             busy,
    output logic             valid,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic [1:0]       fsm_state
);

    localparam int TIMER_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(GATE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GATE = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    logic [TIMER_W-1:0] timer;
    logic [CNT_W-1:0]   edge_cnt;
    logic               sat;
    logic [CNT_W-1:0]   cnt_next;
    logic               sat_next;

    logic sync_a;
    logic sync_q;
    logic prev_q;
    logic level;
    logic edge_pulse;

    // Two-flop synchronizer for the asynchronous input.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_a <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            sync_a <= sig_in;
            sync_q <= sync_a;
        end
    end

`ifdef FREQ_METER_GLITCH_FILTER_EN
    logic hist1;
    logic hist2;

    // Sample history for the majority vote; a level must persist two samples to pass.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist1 <= 1'b0;
            hist2 <= 1'b0;
        end else begin
            hist1 <= sync_q;
            hist2 <= hist1;
        end
    end

    assign level = (sync_q & hist1) | (sync_q & hist2) | (hist1 & hist2);
`else
    assign level = sync_q;
`endif

    // Previous-sample flop for rising-edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level;
        end
    end

    assign edge_pulse = level & ~prev_q;

    // Saturating next value of the edge counter; an edge at full scale sets the sat flag.
    always_comb begin
        cnt_next = edge_cnt;
        sat_next = sat;
        if (edge_pulse) begin
            if (&edge_cnt) begin
                sat_next = 1'b1;
            end else begin
                cnt_next = edge_cnt + 1'b1;
            end
        end
    end

    // Gate FSM with its timer, edge counter and registered outputs. The result is
    // loaded on the last GATE edge so that an edge in the final gate cycle counts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            valid    <= 1'b0;
            count    <= '0;
            overflow <= 1'b0;
            timer    <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    timer    <= '0;
                    edge_cnt <= '0;
                    sat      <= 1'b0;
                    if (start || continuous) begin
                        state <= S_GATE;
                        busy  <= 1'b1;
                    end
                end
                S_GATE: begin
                    edge_cnt <= cnt_next;
                    sat      <= sat_next;
                    if (timer == TIMER_LAST) begin
                        state    <= S_DONE;
                        timer    <= '0;
                        count    <= cnt_next;
                        overflow <= sat_next;
                        valid    <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_DONE: begin
                    timer    <= '0;
                    edge_cnt <= '0;
                    sat      <= 1'b0;
                    if (continuous) begin
                        state <= S_GATE;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: two instances (CNT_W=8 and CNT_W=4, GATE_CYCLES=100)
// share all inputs. Expected results are queued when a window is started and are
// compared when valid appears. Expected counts come from the input pattern: with
// a period that divides the 100-cycle gate, every window sees exactly 100/period rises.
module tb_freq_meter;

    localparam int G = 100;

    logic clk = 1'b0;
    logic reset_n;
    logic sig_in;
    logic start;
    logic continuous;

    logic       busy8, valid8, ovf8;
    logic [7:0] count8;
    logic [1:0] st8;
    logic       busy4, valid4, ovf4;
    logic [3:0] count4;
    logic [1:0] st4;

    freq_meter #(.GATE_CYCLES(G), .CNT_W(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .sig_in(sig_in), .start(start),
        .continuous(continuous), .busy(busy8), .valid(valid8), .count(count8),
        .overflow(ovf8), .fsm_state(st8)
    );

    freq_meter #(.GATE_CYCLES(G), .CNT_W(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .sig_in(sig_in), .start(start),
        .continuous(continuous), .busy(busy4), .valid(valid4), .count(count4),
        .overflow(ovf4), .fsm_state(st4)
    );

    // Clock and cycle counter (cyc = number of rising edges seen so far).
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Pattern generator: period 0 means a static level given by gen_high.
    int gen_period = 0;
    int gen_high   = 0;
    int ph         = 0;
    initial begin
        sig_in = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (gen_period == 0) begin
                sig_in = (gen_high != 0);
            end else begin
                sig_in = (ph < gen_high);
                ph = ph + 1;
                if (ph >= gen_period) ph = 0;
            end
        end
    end

    // Scoreboard queues: expected valid cycle, {overflow,count} for each instance.
    int         exp_cyc_q[$];
    logic [8:0] exp8_q[$];
    logic [4:0] exp4_q[$];
    int         mon_cyc;
    logic [8:0] mon_e8;
    logic [4:0] mon_e4;

    task automatic push_expect(input int c, input logic [8:0] e8, input logic [4:0] e4);
        exp_cyc_q.push_back(c);
        exp8_q.push_back(e8);
        exp4_q.push_back(e4);
    endtask

    // Monitor: every valid pulse is matched against the head of the queue.
    always @(negedge clk) begin
        if (valid8 || valid4) begin
            check("valid_pair", 32'(valid4), 32'(valid8));
            if (exp_cyc_q.size() == 0) begin
                check("unexpected_valid", 32'(valid8 | valid4), 32'd0);
            end else begin
                mon_cyc = exp_cyc_q.pop_front();
                mon_e8  = exp8_q.pop_front();
                mon_e4  = exp4_q.pop_front();
                check("valid_cycle", 32'(cyc), 32'(mon_cyc));
                check("count8", 32'(count8), 32'(mon_e8[7:0]));
                check("ovf8", 32'(ovf8), 32'(mon_e8[8]));
                check("count4", 32'(count4), 32'(mon_e4[3:0]));
                check("ovf4", 32'(ovf4), 32'(mon_e4[4]));
            end
        end
    end

    // Pulse start for one cycle; t returns the number of the edge that sampled it.
    task automatic start_window(output int t);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        t = cyc;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while ((busy8 || exp_cyc_q.size() != 0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("idle_within_budget", 32'(busy8), 32'd0);
        check("no_pending_expect", 32'(exp_cyc_q.size()), 32'd0);
    endtask

    typedef struct {
        int         period;
        int         high;
        logic [7:0] c8;
        logic       o8;
        logic [3:0] c4;
        logic       o4;
    } vec_t;

    vec_t vecs[10];
    int   t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, cycle %0d", cyc);
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog timeout");
    end

    initial begin
        vecs[0] = '{0,  0, 8'd0,  1'b0, 4'd0,  1'b0};   // static low
        vecs[1] = '{0,  1, 8'd0,  1'b0, 4'd0,  1'b0};   // static high
`ifdef FREQ_METER_GLITCH_FILTER_EN
        vecs[2] = '{4,  2, 8'd25, 1'b0, 4'd15, 1'b1};   // clk/4, fastest filtered rate
`else
        vecs[2] = '{2,  1, 8'd50, 1'b0, 4'd15, 1'b1};   // clk/2
`endif
        vecs[3] = '{10, 5, 8'd10, 1'b0, 4'd10, 1'b0};
        vecs[4] = '{4,  2, 8'd25, 1'b0, 4'd15, 1'b1};   // saturates the 4-bit counter
        vecs[5] = '{20, 10, 8'd5, 1'b0, 4'd5,  1'b0};   // overflow clears next window
        vecs[6] = '{5,  2, 8'd20, 1'b0, 4'd15, 1'b1};
        vecs[7] = '{25, 12, 8'd4, 1'b0, 4'd4,  1'b0};
`ifdef FREQ_METER_GLITCH_FILTER_EN
        vecs[8] = '{10, 1, 8'd0,  1'b0, 4'd0,  1'b0};   // 1-clk high glitches rejected
        vecs[9] = '{10, 9, 8'd0,  1'b0, 4'd0,  1'b0};   // 1-clk low glitches rejected
`else
        vecs[8] = '{10, 1, 8'd10, 1'b0, 4'd10, 1'b0};   // 1-clk high pulses counted
        vecs[9] = '{10, 9, 8'd10, 1'b0, 4'd10, 1'b0};   // 1-clk low dips counted
`endif

        // Reset with a toggling input and start held: everything stays cleared.
        reset_n    = 1'b0;
        start      = 1'b0;
        continuous = 1'b0;
        gen_period = 2;
        gen_high   = 1;
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_valid", 32'(valid8), 32'd0);
        check("rst_ovf", 32'(ovf8), 32'd0);
        check("rst_count8", 32'(count8), 32'd0);
        check("rst_count4", 32'(count4), 32'd0);
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_busy", 32'(busy8), 32'd0);
        check("post_rst_state", 32'(st8), 32'd0);

        // Single-shot windows from the vector table.
        for (int i = 0; i < 10; i++) begin
            gen_period = vecs[i].period;
            gen_high   = vecs[i].high;
            repeat (10) @(posedge clk);
            start_window(t);
            push_expect(t + G, {vecs[i].o8, vecs[i].c8}, {vecs[i].o4, vecs[i].c4});
            repeat (G + 1) @(negedge clk);
            check("busy_in_done", 32'(busy8), 32'd1);
            check("valid_at_latency", 32'(valid8), 32'd1);
            check("state_done", 32'(st8), 32'd2);
            @(negedge clk);
            check("busy_cleared", 32'(busy8), 32'd0);
            check("valid_one_cycle", 32'(valid8), 32'd0);
            repeat (5) @(negedge clk);
            check("count8_held", 32'(count8), 32'(vecs[i].c8));
            check("ovf4_held", 32'(ovf4), 32'(vecs[i].o4));
        end

        // Continuous mode: three windows every G+1 cycles, start ignored while busy,
        // continuous dropped inside the third window.
        gen_period = 10;
        gen_high   = 5;
        repeat (10) @(posedge clk);
        @(posedge clk);
        #1 continuous = 1'b1;
        @(posedge clk);
        #1 t = cyc;
        push_expect(t + G,         9'd10, 5'd10);
        push_expect(t + 2 * G + 1, 9'd10, 5'd10);
        push_expect(t + 3 * G + 2, 9'd10, 5'd10);
        repeat (G + 50) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (G) @(posedge clk);
        #1 continuous = 1'b0;
        wait_idle(400);
        repeat (150) @(negedge clk);
        check("cont_end_busy", 32'(busy8), 32'd0);
        check("cont_end_state", 32'(st8), 32'd0);
        check("cont_end_count", 32'(count8), 32'd10);

        // Reset in the middle of a window: no valid, outputs cleared at once.
        start_window(t);
        push_expect(t + G, 9'd10, 5'd10);
        repeat (50) @(posedge clk);
        #1 reset_n = 1'b0;
        exp_cyc_q.delete();
        exp8_q.delete();
        exp4_q.delete();
        #1;
        check("midrst_busy", 32'(busy8), 32'd0);
        check("midrst_count8", 32'(count8), 32'd0);
        check("midrst_count4", 32'(count4), 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (150) @(negedge clk);
        check("midrst_idle", 32'(busy8), 32'd0);
        check("midrst_count_stays", 32'(count8), 32'd0);
        check("midrst_ovf", 32'(ovf4), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
